axis_msg_framer: RTL and testbench

- Stream stage directly upstream of the message counter.
- Accepts an untagged AXI-Stream beat flow, splits it into messages of a programmable beat length and asserts m_tlast on the final beat of each message.
- Registers the stream through a two-entry skid buffer.
- Its m_tvalid && m_tready is the count_enable of the downstream counter; its msg_len drives that counter's rollover_val.

---
 rtl/axis_pkg.sv | 18 +
 rtl/axis_skid_buffer.sv | 61 ++++++
 rtl/axis_msg_framer.sv | 126 ++++++++++++
 tb/tb_axis_msg_framer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream message framing slice.
// - framer_state_t : framer FSM state (no message open / message in progress)
// - axis_beat_t    : one buffered stream beat (last flag + data) at the default data width
package axis_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } framer_state_t;

    typedef struct packed {
        logic                       last;
        logic [AXIS_DATA_WIDTH-1:0] data;
    } axis_beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: a main output register plus one skid register, giving a
// fully registered ready/valid path with 1 beat/cycle throughput.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   s_data/s_valid      : upstream beat (WIDTH bits) and valid
//   s_ready             : upstream ready, low while the skid register is occupied or in reset
//   m_data/m_valid      : downstream beat and valid (main register)
//   m_ready             : downstream ready
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] main_data_q;
    logic             main_valid_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             skid_valid_q;
    logic             s_acc;
    logic             m_acc;

    assign s_ready = !skid_valid_q && !rst;
    assign s_acc   = s_valid && s_ready;
    assign m_acc   = main_valid_q && m_ready;
    assign m_data  = main_data_q;
    assign m_valid = main_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q  <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else if (m_acc || !main_valid_q) begin
            // Main register is free this cycle. A held skid beat has priority;
            // s_ready is low whenever the skid is full, so no input beat competes.
            if (skid_valid_q) begin
                main_data_q  <= skid_data_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (s_acc) begin
                main_data_q  <= s_data;
                main_valid_q <= 1'b1;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (s_acc) begin
            // Main is stalled: park the beat so the upstream need not see ready drop yet.
            skid_data_q  <= s_data;
            skid_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_msg_framer.sv
// Splits an untagged AXI-Stream beat flow into messages of msg_len beats and flags the
// final beat of each message with m_tlast. Output is registered through a skid buffer.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   msg_len               : beats per message, latched at message start (0 means 1)
//   s_tdata/s_tvalid      : upstream beat, s_tready : upstream ready
//   m_tdata/m_tvalid/m_tlast, m_tready : downstream beat and handshake
//   beat_count            : beats accepted in the currently open message
//   msg_count             : messages completed on the master side (wrapping)
//   msg_done              : one-cycle pulse the cycle after a last-beat master handshake
module axis_msg_framer
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = AXIS_DATA_WIDTH,
    parameter int unsigned NUM_COUNT_BITS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_COUNT_BITS-1:0] msg_len,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic [NUM_COUNT_BITS-1:0] beat_count,
    output logic [NUM_COUNT_BITS-1:0] msg_count,
    output logic                      msg_done
);

    localparam logic [NUM_COUNT_BITS-1:0] OneCnt = {{(NUM_COUNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [NUM_COUNT_BITS:0]   OneExt = {{NUM_COUNT_BITS{1'b0}}, 1'b1};

    framer_state_t             state_q, state_d;
    logic [NUM_COUNT_BITS-1:0] beat_q, beat_d;
    logic [NUM_COUNT_BITS-1:0] len_q, len_d;
    logic [NUM_COUNT_BITS-1:0] msg_count_q;
    logic                      msg_done_q;
    logic [NUM_COUNT_BITS-1:0] len_eff;
    logic [NUM_COUNT_BITS:0]   beat_next_ext;
    logic                      tag_last;
    logic                      s_acc;
    logic                      m_acc;
    logic [DATA_WIDTH:0]       buf_in;
    logic [DATA_WIDTH:0]       buf_out;

    assign s_acc   = s_tvalid && s_tready;
    assign m_acc   = m_tvalid && m_tready;
    assign len_eff = (msg_len == '0) ? OneCnt : msg_len;
    // One extra bit so a full-scale length never wraps the comparison.
    assign beat_next_ext = {1'b0, beat_q} + OneExt;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        len_d    = len_q;
        tag_last = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_acc) begin
                    len_d = len_eff;
                    if (len_eff == OneCnt) begin
                        tag_last = 1'b1;
                    end else begin
                        state_d = ACTIVE;
                        beat_d  = OneCnt;
                    end
                end
            end
            ACTIVE: begin
                if (s_acc) begin
                    if (beat_next_ext == {1'b0, len_q}) begin
                        tag_last = 1'b1;
                        beat_d   = '0;
                        state_d  = IDLE;
                    end else begin
                        beat_d = beat_next_ext[NUM_COUNT_BITS-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            len_q       <= '0;
            msg_count_q <= '0;
            msg_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            msg_done_q <= m_acc && m_tlast;
            if (m_acc && m_tlast) begin
                msg_count_q <= msg_count_q + OneCnt;
            end
        end
    end

    // The last flag travels with its beat so stalls cannot misalign it.
    assign buf_in = {tag_last, s_tdata};

    axis_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_data  (buf_in),
        .s_valid (s_tvalid),
        .s_ready (s_tready),
        .m_data  (buf_out),
        .m_valid (m_tvalid),
        .m_ready (m_tready)
    );

    assign m_tlast    = buf_out[DATA_WIDTH];
    assign m_tdata    = buf_out[DATA_WIDTH-1:0];
    assign beat_count = beat_q;
    assign msg_count  = msg_count_q;
    assign msg_done   = msg_done_q;

endmodule

// File: tb/tb_axis_msg_framer.sv
// Self-checking bench for axis_msg_framer: directed scenarios plus a randomized run,
// all compared every cycle against a queue-based behavioural model.
module tb_axis_msg_framer;
    import axis_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] msg_len = 16'd4;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [15:0] beat_count;
    logic [15:0] msg_count;
    logic        msg_done;

    axis_msg_framer #(
        .DATA_WIDTH     (32),
        .NUM_COUNT_BITS (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .msg_len    (msg_len),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .beat_count (beat_count),
        .msg_count  (msg_count),
        .msg_done   (msg_done)
    );

    always #5 clk = ~clk;

    // Reference model: beats in flight in output order, plus message framing position.
    axis_beat_t  q[$];
    int          pos      = 0;
    int          cur_len  = 0;
    logic [15:0] mcount   = '0;
    logic        done_exp = 1'b0;
    int          accepted = 0;
    bit          rand_data = 0;
    logic [31:0] next_data = '0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One clock cycle: inputs already driven; compare at negedge, advance model at posedge.
    task automatic step();
        bit         sacc;
        bit         macc;
        bit         exp_rdy;
        axis_beat_t b;
        @(negedge clk);
        exp_rdy = !rst && (q.size() < 2);
        check("s_tready", s_tready, exp_rdy);
        check("m_tvalid", m_tvalid, q.size() > 0);
        if (q.size() > 0) begin
            check("m_tdata", m_tdata, q[0].data);
            check("m_tlast", m_tlast, q[0].last);
        end
        check("beat_count", beat_count, pos);
        check("msg_count", msg_count, mcount);
        check("msg_done", msg_done, done_exp);
        sacc = s_tvalid && exp_rdy;
        macc = (q.size() > 0) && m_tready;
        @(posedge clk);
        if (rst) begin
            q.delete();
            pos      = 0;
            cur_len  = 0;
            mcount   = '0;
            done_exp = 1'b0;
        end else begin
            done_exp = 1'b0;
            if (macc) begin
                done_exp = q[0].last;
                if (q[0].last) mcount = mcount + 16'd1;
                void'(q.pop_front());
            end
            if (sacc) begin
                if (pos == 0) cur_len = (msg_len == 0) ? 1 : int'(msg_len);
                pos++;
                b.data = s_tdata;
                b.last = (pos == cur_len);
                q.push_back(b);
                if (pos == cur_len) pos = 0;
                accepted++;
                next_data = rand_data ? $urandom : next_data + 32'd1;
            end
        end
        #1;
    endtask

    task automatic cyc(input bit v, input bit r);
        s_tvalid = v;
        m_tready = r;
        s_tdata  = next_data;
        step();
    endtask

    task automatic send(input int n, input bit r);
        int target;
        int guard;
        target = accepted + n;
        guard  = 0;
        while (accepted < target && guard < 200) begin
            cyc(1'b1, r);
            guard++;
        end
        check("send_timeout", accepted, target);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 50) begin
            cyc(1'b0, 1'b1);
            guard++;
        end
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int base;
        int guard;

        // Reset: ready must stay low while rst is high.
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_msg_count", msg_count, 0);
        rst = 1'b0;
        next_data = '0;

        // Two 4-beat messages, streaming.
        msg_len = 16'd4;
        send(8, 1'b1);
        drain();
        check("t1_msg_count", msg_count, 2);

        // Length 0 behaves as 1, then length 1: every beat is last.
        msg_len = 16'd0;
        send(1, 1'b1);
        msg_len = 16'd1;
        send(2, 1'b1);
        drain();
        check("t2_msg_count", msg_count, 5);

        // Backpressure: one extra beat into skid, ready low until release.
        msg_len = 16'd3;
        base = accepted;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        repeat (5) cyc(accepted - base < 3, 1'b0);
        check("t3_accepted_during_stall", accepted - base, 3);
        drain();
        check("t3_msg_count", msg_count, 6);

        // Length change mid-message only takes effect at the next message.
        msg_len = 16'd4;
        send(1, 1'b1);
        msg_len = 16'd2;
        send(7, 1'b1);
        drain();
        check("t4_msg_count", msg_count, 9);

        // Reset with two beats buffered mid-message.
        msg_len = 16'd3;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        check("t5_m_tvalid", m_tvalid, 0);
        check("t5_beat_count", beat_count, 0);
        check("t5_msg_count", msg_count, 0);
        rst = 1'b0;
        next_data = 32'h100;
        send(3, 1'b1);
        drain();
        check("t5_msg_count_after", msg_count, 1);

        // Randomized handshakes, 1000 beats of length-5 messages.
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        rand_data = 1;
        next_data = $urandom;
        msg_len   = 16'd5;
        base  = accepted;
        guard = 0;
        while (accepted - base < 1000 && guard < 20000) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            guard++;
        end
        check("rand_beats", accepted - base, 1000);
        drain();
        check("rand_msg_count", msg_count, 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
